cpu_axi_bridge: RTL and testbench

//  Responder end of the core's SRAM-like req/addr_ok/data_ok interface: services the inst port (read-only) and the

---
 rtl/bridge_pkg.sv | 43 ++++
 rtl/bridge_wstrb_gen.sv | 12 +
 rtl/cpu_axi_bridge.sv | 193 +++++++++++++++++++
 tb/tb_cpu_axi_bridge.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// bridge_pkg: shared state codes, owner tags, AXI constants and the
// byte-strobe helper for cpu_axi_bridge.
package bridge_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AR   = 3'd1;
  localparam logic [2:0] ST_R    = 3'd2;
  localparam logic [2:0] ST_AW_W = 3'd3;
  localparam logic [2:0] ST_B    = 3'd4;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [7:0] AXI_LEN   = 8'd0;
  localparam logic [1:0] AXI_BURST = 2'b01;
  localparam logic [1:0] AXI_LOCK  = 2'b00;
  localparam logic [3:0] AXI_CACHE = 4'd0;
  localparam logic [2:0] AXI_PROT  = 3'd0;

  typedef struct packed {
    logic        owner;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // size 3 is illegal on the core side; treat it as a full word
  function automatic logic [3:0] strb(
    input logic [1:0] size,
    input logic [1:0] addr
  );
    logic [3:0] s;
    s = 4'b1111;
    case (size)
      2'd0:    s = 4'b0001 << addr;
      2'd1:    s = 4'b0011 << {addr[1], 1'b0};
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bridge_wstrb_gen.sv
// bridge_wstrb_gen: combinational write byte-lane strobes
// from the latched access size and low address bits.
module bridge_wstrb_gen (
  input  logic [1:0] size,
  input  logic [1:0] addr,
  output logic [3:0] wstrb
);
  import bridge_pkg::*;

  assign wstrb = strb(size, addr);

endmodule

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: SRAM-like inst/data ports to single-beat AXI3 master.
// BRIDGE_POSTED_WRITE_EN: stores ack early, AW/W/B finish behind it.
module cpu_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        aclk,
  input  logic        aresetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,

  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  import bridge_pkg::*;

  logic [2:0] state;
  req_t       cur;
  req_t       greq;
  logic       aw_done;
  logic       w_done;
  logic       grant_d;
  logic       grant_i;
  logic       aw_hs;
  logic       w_hs;
  logic       wr_fin;
  logic       r_fin;
  logic       data_rd_ok;
  logic       unused_in;

  assign unused_in = ^{inst_wr, rid, rresp, rlast, bid, bresp};

  assign grant_d = aresetn && (state == ST_IDLE) && data_req;
  assign grant_i = aresetn && (state == ST_IDLE) && !data_req
                   && inst_req;

  assign data_addr_ok = grant_d;
  assign inst_addr_ok = grant_i;

  // inst port is read-only: its wr bit is never latched
  always_comb begin
    greq = '{owner: OWN_INST, wr: 1'b0, size: inst_size,
             addr: inst_addr, wdata: inst_wdata};
    if (data_req)
      greq = '{owner: OWN_DATA, wr: data_wr, size: data_size,
               addr: data_addr, wdata: data_wdata};
  end

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign wr_fin = (aw_done || aw_hs) && (w_done || w_hs);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state   <= ST_IDLE;
      cur     <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (grant_d || grant_i) begin
            cur   <= greq;
            state <= greq.wr ? ST_AW_W : ST_AR;
          end
        end
        ST_AR: if (arready) state <= ST_R;
        ST_R:  if (rvalid) state <= ST_IDLE;
        ST_AW_W: begin
          aw_done <= aw_done || aw_hs;
          w_done  <= w_done || w_hs;
          if (wr_fin) begin
            state   <= ST_B;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        ST_B: if (bvalid) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign arvalid = (state == ST_AR);
  assign rready  = (state == ST_R);
  assign awvalid = (state == ST_AW_W) && !aw_done;
  assign wvalid  = (state == ST_AW_W) && !w_done;
  assign bready  = (state == ST_B);

  assign arid    = (cur.owner == OWN_DATA) ? DATA_ID : INST_ID;
  assign araddr  = cur.addr;
  assign arlen   = AXI_LEN;
  assign arsize  = {1'b0, cur.size};
  assign arburst = AXI_BURST;
  assign arlock  = AXI_LOCK;
  assign arcache = AXI_CACHE;
  assign arprot  = AXI_PROT;

  assign awid    = DATA_ID;
  assign awaddr  = cur.addr;
  assign awlen   = AXI_LEN;
  assign awsize  = {1'b0, cur.size};
  assign awburst = AXI_BURST;
  assign awlock  = AXI_LOCK;
  assign awcache = AXI_CACHE;
  assign awprot  = AXI_PROT;

  assign wid   = DATA_ID;
  assign wdata = cur.wdata;
  assign wlast = 1'b1;

  bridge_wstrb_gen u_wstrb (
    .size  (cur.size),
    .addr  (cur.addr[1:0]),
    .wstrb (wstrb)
  );

  assign r_fin        = rready && rvalid;
  assign inst_data_ok = r_fin && (cur.owner == OWN_INST);
  assign data_rd_ok   = r_fin && (cur.owner == OWN_DATA);
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

`ifdef BRIDGE_POSTED_WRITE_EN
  // store ack fires on the first AW_W cycle; IDLE is only
  // re-entered after B, which holds off any later request
  logic posted_ok;

  always_ff @(posedge aclk) begin
    if (!aresetn) posted_ok <= 1'b0;
    else          posted_ok <= grant_d && data_wr;
  end

  assign data_data_ok = data_rd_ok || posted_ok;
`else
  assign data_data_ok = data_rd_ok || (bready && bvalid);
`endif

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: random traffic on both ports against an AXI
// slave model, byte-level reference memory and response scoreboard.
`timescale 1ns/1ps
module tb_cpu_axi_bridge;

  localparam logic [31:0] BASE = 32'h1fc0_0000;

  logic        aclk;
  logic        aresetn;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  arid, arcache, awid, awcache, wid, wstrb, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready;

  cpu_axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    bit          port;
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_strb;
    int          acc;
  } txn_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  txn_t        rsp_q[$];
  txn_t        axi_q[$];
  logic [7:0]  refb[64];
  logic [31:0] smem[16];
  bit          axi_busy = 0;
  bit          hold_r = 0;
  bit          ar_held = 0;
  bit          orphan_go = 0;
  bit          orphan_done = 0;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event, required none", nm);
  endtask

  // expected lanes: an access of nb bytes covers the nb-aligned
  // group of byte lanes that contains its address
  task automatic accept(input bit port, input bit wr,
                        input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd);
    txn_t t;
    int off, base, nb, lo;
    chk("one_in_flight", {31'd0, axi_busy}, 0);
    chk("prev_rsp_done", rsp_q.size(), 0);
    if (!port) chk("data_priority", {31'd0, data_req}, 0);
    off  = int'(a[5:0]);
    base = off - (off % 4);
    nb   = (sz >= 2) ? 4 : (1 << sz);
    lo   = ((off % 4) / nb) * nb;
    t.exp_strb = 4'd0;
    for (int k = lo; k < lo + nb; k++) begin
      t.exp_strb[k] = 1'b1;
      if (wr) refb[base + k] = wd[8*k +: 8];
    end
    t.exp_rdata = {refb[base+3], refb[base+2],
                   refb[base+1], refb[base]};
    t.port  = port;
    t.wr    = wr;
    t.addr  = a;
    t.size  = sz;
    t.wdata = wd;
    t.acc   = cyc;
    rsp_q.push_back(t);
    axi_q.push_back(t);
    axi_busy = 1;
  endtask

  task automatic inst_issue(input logic [31:0] a);
    int n = 0;
    @(posedge aclk); #1;
    inst_req   = 1'b1;
    inst_wr    = ($urandom_range(0, 4) == 0);
    inst_size  = 2'd2;
    inst_addr  = a;
    inst_wdata = $urandom;
    do begin @(negedge aclk); n++; end
    while (!inst_addr_ok && n < 500);
    if (inst_addr_ok) accept(1'b0, 1'b0, 2'd2, a, 32'd0);
    else fail("inst_addr_ok_timeout");
    @(posedge aclk); #1;
    inst_req = 1'b0;
    inst_wr  = 1'b0;
  endtask

  task automatic data_issue(input bit wr, input logic [1:0] sz,
                            input logic [31:0] a,
                            input logic [31:0] wd);
    int n = 0;
    @(posedge aclk); #1;
    data_req   = 1'b1;
    data_wr    = wr;
    data_size  = sz;
    data_addr  = a;
    data_wdata = wd;
    do begin @(negedge aclk); n++; end
    while (!data_addr_ok && n < 500);
    if (data_addr_ok) accept(1'b1, wr, sz, a, wd);
    else fail("data_addr_ok_timeout");
    @(posedge aclk); #1;
    data_req = 1'b0;
  endtask

  task automatic inst_loop(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge aclk);
      inst_issue(BASE + 32'(4 * $urandom_range(0, 15)));
    end
  endtask

  task automatic data_loop(input int cnt);
    logic [1:0] sz;
    int off;
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge aclk);
      sz  = ($urandom_range(0, 7) == 0) ? 2'd3
                                        : 2'($urandom_range(0, 2));
      off = $urandom_range(0, 63);
      if (sz == 2'd1) off = off - (off % 2);
      if (sz >= 2'd2) off = off - (off % 4);
      data_issue(1'($urandom_range(0, 1)), sz,
                 BASE + 32'(off), $urandom);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rsp_q.size() != 0 || axi_busy) && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    chk("drain_in_time", {31'd0, n < 2000}, 1);
  endtask

  // response monitor
  initial begin : monitor
    txn_t t;
    logic [31:0] rd;
    forever begin
      @(negedge aclk);
      if (inst_data_ok || data_data_ok) begin
        chk("single_data_ok",
            {31'd0, inst_data_ok && data_data_ok}, 0);
        if (rsp_q.size() == 0) fail("unexpected_data_ok");
        else begin
          t = rsp_q.pop_front();
          chk("ok_port", {31'd0, data_data_ok}, {31'd0, t.port});
          rd = data_data_ok ? data_rdata : inst_rdata;
          if (!t.wr) begin
            chk("rdata", rd, t.exp_rdata);
            chk("r_hs_at_ok", {31'd0, rvalid && rready}, 1);
            chk("rd_latency", {31'd0, cyc >= t.acc + 2}, 1);
          end else begin
`ifdef BRIDGE_POSTED_WRITE_EN
            chk("posted_ack_cyc", cyc, t.acc + 1);
`else
            chk("b_hs_at_ok", {31'd0, bvalid && bready}, 1);
`endif
          end
        end
      end
    end
  end

  // AXI slave model
  initial begin : slave
    txn_t t;
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    bit ar_wait, aw_got, w_got, r_act, b_act, orph_on, orph_st;
    int r_cnt, b_cnt, ar_stall, orph;
    logic [31:0] ar_wait_addr, r_addr, aw_addr, w_data;
    logic [3:0] w_strb;
    ar_wait = 0; aw_got = 0; w_got = 0; r_act = 0; b_act = 0;
    orph_on = 0; orph_st = 0; r_cnt = 0; b_cnt = 0;
    ar_stall = 0; orph = 0;
    ar_wait_addr = 0; r_addr = 0; aw_addr = 0; w_data = 0;
    w_strb = 0;
    arready = 0; rvalid = 0; rdata = 0; rid = 0; rresp = 0;
    rlast = 1; awready = 0; wready = 0; bvalid = 0; bid = 4'd1;
    bresp = 0;
    forever begin
      @(negedge aclk);
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      if (ar_wait) begin
        chk("ar_valid_hold", {31'd0, arvalid}, 1);
        chk("ar_addr_hold", araddr, ar_wait_addr);
      end
      ar_wait = arvalid && !arready;
      ar_wait_addr = araddr;
      if (orph_on) begin
        chk("orphan_rready", {31'd0, rready}, 0);
        chk("orphan_data_ok",
            {31'd0, inst_data_ok || data_data_ok}, 0);
      end
      if (ar_hs) begin
        chk("ar_consts", {arlen, arburst, arlock, arcache, arprot},
            {8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
        if (axi_q.size() == 0) fail("ar_unexpected");
        else begin
          t = axi_q.pop_front();
          chk("ar_is_read", {31'd0, t.wr}, 0);
          chk("arid", arid, t.port ? 4'd1 : 4'd0);
          chk("araddr", araddr, t.addr);
          chk("arsize", arsize, {1'b0, t.size});
        end
        r_addr = araddr;
        if (hold_r) ar_held = 1;
        else begin
          r_act = 1;
          r_cnt = $urandom_range(0, 2);
        end
      end
      if (r_hs) begin r_act = 0; axi_busy = 0; end
      if (aw_hs || w_hs) begin
        if (axi_q.size() == 0) fail("aw_w_unexpected");
        else t = axi_q[0];
      end
      if (aw_hs && axi_q.size() != 0) begin
        chk("aw_is_write", {31'd0, t.wr}, 1);
        chk("awaddr", awaddr, t.addr);
        chk("awid_awsize", {awid, awsize}, {4'd1, 1'b0, t.size});
        chk("aw_consts", {awlen, awburst, awlock, awcache, awprot},
            {8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
        aw_got = 1;
        aw_addr = awaddr;
      end
      if (w_hs && axi_q.size() != 0) begin
        chk("wstrb", wstrb, t.exp_strb);
        chk("wdata", wdata, t.wdata);
        chk("wlast_wid", {wlast, wid}, {1'b1, 4'd1});
        w_got = 1;
        w_data = wdata;
        w_strb = wstrb;
      end
      if (aw_got && w_got) begin
        for (int k = 0; k < 4; k++)
          if (w_strb[k]) smem[aw_addr[5:2]][8*k +: 8] = w_data[8*k +: 8];
        void'(axi_q.pop_front());
        aw_got = 0;
        w_got = 0;
        b_act = 1;
        b_cnt = $urandom_range(0, 2);
      end
      if (b_hs) begin b_act = 0; axi_busy = 0; end
      if (orphan_go && !orph_st) begin orph_st = 1; orph = 4; end
      @(posedge aclk); #1;
      if (ar_stall > 0) begin arready = 0; ar_stall--; end
      else if ($urandom_range(0, 9) == 0) begin
        arready = 0;
        ar_stall = 5;
      end else arready = ($urandom_range(0, 3) != 0);
      awready = ($urandom_range(0, 2) != 0);
      wready  = ($urandom_range(0, 2) != 0);
      rresp   = 2'($urandom);
      if (orph > 0) begin
        rvalid = 1;
        rdata = 32'hdead_beef;
        orph--;
        orph_on = 1;
      end else if (orph_on) begin
        orph_on = 0;
        rvalid = 0;
        orphan_done = 1;
      end else if (r_act) begin
        if (r_cnt == 0) begin
          rvalid = 1;
          rdata = smem[r_addr[5:2]];
        end else r_cnt--;
      end else begin
        rvalid = 0;
        rdata = $urandom;
      end
      if (b_act) begin
        if (b_cnt == 0) bvalid = 1;
        else b_cnt--;
      end else bvalid = 0;
    end
  end

  initial begin : main
    int n;
    logic [31:0] w;
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      smem[i] = w;
      for (int k = 0; k < 4; k++) refb[4*i + k] = w[8*k +: 8];
    end
    aresetn = 0;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2;
    inst_addr = 0; inst_wdata = 0;
    data_req = 1; data_wr = 0; data_size = 2'd2;
    data_addr = BASE; data_wdata = 0;
    repeat (3) begin
      @(negedge aclk);
      chk("reset_outputs",
          {arvalid, awvalid, wvalid, rready, bready, inst_addr_ok,
           data_addr_ok, inst_data_ok, data_data_ok}, 0);
    end
    @(posedge aclk); #1;
    data_req = 0;
    aresetn = 1;

    fork
      inst_loop(60);
      data_loop(80);
    join
    wait_idle();

    hold_r = 1;
    data_issue(1'b0, 2'd2, BASE + 32'd8, 32'd0);
    n = 0;
    while (!ar_held && n < 200) begin @(negedge aclk); n++; end
    chk("ar_before_reset", {31'd0, ar_held}, 1);
    @(posedge aclk); #1;
    aresetn = 0;
    @(posedge aclk); #1;
    aresetn = 1;
    rsp_q.delete();
    axi_q.delete();
    axi_busy = 0;
    orphan_go = 1;
    n = 0;
    while (!orphan_done && n < 50) begin @(negedge aclk); n++; end
    chk("orphan_finished", {31'd0, orphan_done}, 1);
    hold_r = 0;
    data_issue(1'b0, 2'd2, BASE + 32'd12, 32'd0);
    inst_issue(BASE + 32'd16);

    fork
      inst_loop(30);
      data_loop(40);
    join
    wait_idle();
    chk("scoreboard_empty", rsp_q.size() + axi_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
